// File: rtl/magcomp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package magcomp_pkg;

  // Controller states: waiting for a request, or scanning slices.
  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  // Result encoding, ordered {agb, aeb, alb}.
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

endpackage

// File: rtl/seq_magcomp_serial_if.sv
// Request/result bundle of the serial magnitude comparator.
interface seq_magcomp_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             agb;
  logic             aeb;
  logic             alb;

  // Requester side: drives operands and start, observes status and result.
  modport master (
    output start, a, b,
    input  busy, done, agb, aeb, alb
  );

  // Comparator side.
  modport slave (
    input  start, a, b,
    output busy, done, agb, aeb, alb
  );
endinterface

// File: rtl/magcomp_slice2.sv
// Purely combinational 2-bit magnitude comparator slice.
module magcomp_slice2 (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic       o_agb,
  output logic       o_aeb,
  output logic       o_alb
);

  assign o_agb = (i_a > i_b);
  assign o_aeb = (i_a == i_b);
  assign o_alb = (i_a < i_b);

endmodule

// File: rtl/seq_magcomp_serial.sv
// Sequential N-bit magnitude comparator: scans the captured operands
// MSB-first one 2-bit slice per clock and stops at the first unequal slice.
module seq_magcomp_serial
  import magcomp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_magcomp_serial_if.slave   bus
);

  localparam int SLICES = WIDTH / 2;
  localparam int IDXW   = (SLICES > 1) ? $clog2(SLICES) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic [IDXW-1:0]  w_idx_nxt;
  logic [2:0]       r_res;
  logic [2:0]       w_res_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_load;
  logic [1:0]       w_a_sl;
  logic [1:0]       w_b_sl;
  logic             w_agb;
  logic             w_aeb;
  logic             w_alb;

  // Only the slice under the index reaches the single comparator slice.
  assign w_a_sl = r_a[{r_idx, 1'b0} +: 2];
  assign w_b_sl = r_b[{r_idx, 1'b0} +: 2];

  magcomp_slice2 u_slice (
    .i_a   (w_a_sl),
    .i_b   (w_b_sl),
    .o_agb (w_agb),
    .o_aeb (w_aeb),
    .o_alb (w_alb)
  );

  // Next-state, index, result and done-pulse decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_res_nxt   = r_res;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_idx_nxt   = IDXW'(SLICES - 1);
          w_state_nxt = CMP;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CMP: begin
        if (w_agb) begin
          w_res_nxt   = RES_GT;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_alb) begin
          w_res_nxt   = RES_LT;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_idx == IDXW'(0)) begin
          // Every slice matched down to the LSB pair.
          w_res_nxt   = RES_EQ;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_idx_nxt   = r_idx - IDXW'(1);
          w_state_nxt = CMP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Control and result registers; reset discards any compare in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_res   <= RES_NONE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_res   <= w_res_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Operand capture on an accepted start; later bus changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_load) begin
      r_a <= bus.a;
      r_b <= bus.b;
    end
  end

  assign bus.busy = (r_state == CMP);
  assign bus.done = r_done;
  assign bus.agb  = r_res[2];
  assign bus.aeb  = r_res[1];
  assign bus.alb  = r_res[0];

endmodule

// File: tb/tb_seq_magcomp_serial.sv
// Directed self-checking bench for seq_magcomp_serial (WIDTH=8 and WIDTH=4).
module tb_seq_magcomp_serial;
  import magcomp_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] model_res8 = 3'b000;

  seq_magcomp_serial_if #(.WIDTH(8)) bus8 ();
  seq_magcomp_serial_if #(.WIDTH(4)) bus4 ();

  seq_magcomp_serial #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  seq_magcomp_serial #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 compare: start for one cycle, then wait for done.
  task automatic run8(input string tag, input logic [7:0] va, input logic [7:0] vb,
                      input logic [2:0] exp_res, input int exp_lat);
    int k;
    bit seen;
    bus8.a = va;
    bus8.b = vb;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    check({tag, "_busy_on"}, {31'd0, bus8.busy}, 32'd1);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 12) begin
      tick();
      k++;
      if (bus8.done) begin
        seen = 1'b1;
      end else begin
        check({tag, "_hold"}, {29'd0, bus8.agb, bus8.aeb, bus8.alb}, {29'd0, model_res8});
        check({tag, "_busy"}, {31'd0, bus8.busy}, 32'd1);
      end
    end
    check({tag, "_lat"}, k, exp_lat);
    check({tag, "_res"}, {29'd0, bus8.agb, bus8.aeb, bus8.alb}, {29'd0, exp_res});
    check({tag, "_busy_off"}, {31'd0, bus8.busy}, 32'd0);
    model_res8 = exp_res;
    tick();
    check({tag, "_done_pulse"}, {31'd0, bus8.done}, 32'd0);
  endtask

  // One WIDTH=4 compare with a bounded wait for done.
  task automatic run4(input logic [3:0] va, input logic [3:0] vb,
                      input logic [2:0] exp_res, input int exp_lat);
    int k;
    bit seen;
    bus4.a = va;
    bus4.b = vb;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 6) begin
      tick();
      k++;
      if (bus4.done) seen = 1'b1;
    end
    check($sformatf("w4_lat_%h_%h", va, vb), k, exp_lat);
    check($sformatf("w4_res_%h_%h", va, vb), {29'd0, bus4.agb, bus4.aeb, bus4.alb}, {29'd0, exp_res});
  endtask

  initial begin
    logic [2:0] er;
    int el;
    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
    bus4.start = 1'b0; bus4.a = 4'h0;  bus4.b = 4'h0;

    // Reset held, then released.
    repeat (3) tick();
    check("rst_busy", {31'd0, bus8.busy}, 32'd0);
    check("rst_done", {31'd0, bus8.done}, 32'd0);
    check("rst_res", {29'd0, bus8.agb, bus8.aeb, bus8.alb}, 32'd0);
    check("rst_res4", {29'd0, bus4.agb, bus4.aeb, bus4.alb}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", {31'd0, bus8.busy}, 32'd0);
    check("post_rst_res", {29'd0, bus8.agb, bus8.aeb, bus8.alb}, 32'd0);

    // MSB slice differs: one-cycle compare.
    run8("c5_45", 8'hC5, 8'h45, RES_GT, 1);
    // Equal operands and LSB-only difference: full scan.
    run8("5a_5a", 8'h5A, 8'h5A, RES_EQ, 4);
    run8("12_13", 8'h12, 8'h13, RES_LT, 4);
    run8("34_24", 8'h34, 8'h24, RES_GT, 2);

    // start held high: the next compare is accepted in the done cycle.
    bus8.a = 8'h80; bus8.b = 8'h7F; bus8.start = 1'b1;
    tick();
    check("b2b_e0_busy", {31'd0, bus8.busy}, 32'd1);
    check("b2b_e0_done", {31'd0, bus8.done}, 32'd0);
    tick();
    check("b2b_e1_done", {31'd0, bus8.done}, 32'd1);
    check("b2b_e1_res", {29'd0, bus8.agb, bus8.aeb, bus8.alb}, {29'd0, RES_GT});
    tick();
    check("b2b_e2_done", {31'd0, bus8.done}, 32'd0);
    check("b2b_e2_busy", {31'd0, bus8.busy}, 32'd1);
    tick();
    check("b2b_e3_done", {31'd0, bus8.done}, 32'd1);
    check("b2b_e3_res", {29'd0, bus8.agb, bus8.aeb, bus8.alb}, {29'd0, RES_GT});
    bus8.start = 1'b0;
    tick();
    check("b2b_end_busy", {31'd0, bus8.busy}, 32'd0);
    model_res8 = RES_GT;

    // Operand and start changes while busy have no effect.
    bus8.a = 8'h5A; bus8.b = 8'h5B; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    check("tog_e1_done", {31'd0, bus8.done}, 32'd0);
    bus8.a = 8'hFF; bus8.b = 8'h00; bus8.start = 1'b1;
    tick();
    check("tog_e2_done", {31'd0, bus8.done}, 32'd0);
    check("tog_e2_res", {29'd0, bus8.agb, bus8.aeb, bus8.alb}, {29'd0, RES_GT});
    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'hFF;
    tick();
    check("tog_e3_done", {31'd0, bus8.done}, 32'd0);
    tick();
    check("tog_e4_done", {31'd0, bus8.done}, 32'd1);
    check("tog_e4_res", {29'd0, bus8.agb, bus8.aeb, bus8.alb}, {29'd0, RES_LT});
    tick();
    check("tog_no_queue", {31'd0, bus8.busy}, 32'd0);

    // Asynchronous reset mid-compare (4-slice compare, reset after 2 edges).
    bus8.a = 8'h00; bus8.b = 8'h01; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    check("ar_busy_before", {31'd0, bus8.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", {31'd0, bus8.busy}, 32'd0);
    check("ar_done", {31'd0, bus8.done}, 32'd0);
    check("ar_res", {29'd0, bus8.agb, bus8.aeb, bus8.alb}, 32'd0);
    tick();
    rst_n = 1'b1;
    model_res8 = RES_NONE;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ar_no_done", {31'd0, bus8.done}, 32'd0);
    end
    check("ar_res_after", {29'd0, bus8.agb, bus8.aeb, bus8.alb}, 32'd0);

    // Operation resumes normally after reset.
    run8("after_rst", 8'h00, 8'hFF, RES_LT, 1);

    // WIDTH=4 exhaustive sweep.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        if (ia > ib)      er = RES_GT;
        else if (ia < ib) er = RES_LT;
        else              er = RES_EQ;
        el = ((ia >> 2) != (ib >> 2)) ? 1 : 2;
        run4(4'(ia), 4'(ib), er, el);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
